// File: rtl/quadrature_position_tracker_if.sv
// rtl/quadrature_position_tracker_if.sv - encoder inputs and position/velocity outputs of the quadrature tracker
interface quadrature_position_tracker_if #(
  parameter int POS_WIDTH    = 13,
  parameter int PERIOD_WIDTH = 16
);
  logic                    enable;
  logic                    enc_a;
  logic                    enc_b;
  logic                    enc_index;
  logic                    clear_error;
  logic [POS_WIDTH-1:0]    cycle_position;
  logic                    direction;
  logic                    step_valid;
  logic [PERIOD_WIDTH-1:0] step_period;
  logic                    quad_error;

  modport master (
    output enable, enc_a, enc_b, enc_index, clear_error,
    input  cycle_position, direction, step_valid, step_period, quad_error
  );

  modport slave (
    input  enable, enc_a, enc_b, enc_index, clear_error,
    output cycle_position, direction, step_valid, step_period, quad_error
  );
endinterface

// File: rtl/quadrature_position_tracker.sv
// rtl/quadrature_position_tracker.sv - quadrature decoder giving wrapped electrical position and step period
// Optional index resync enabled by defining INDEX_RESYNC_EN.
module quadrature_position_tracker #(
  parameter int COUNTS_PER_CYCLE = 1170,
  parameter int POS_WIDTH        = 13,
  parameter int SYNC_STAGES      = 2,
  parameter int PERIOD_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  quadrature_position_tracker_if.slave  bus
);
  localparam logic [POS_WIDTH-1:0]    POS_MAX    = POS_WIDTH'(COUNTS_PER_CYCLE - 1);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

  logic [SYNC_STAGES-1:0]  a_sync_q;
  logic [SYNC_STAGES-1:0]  b_sync_q;
  logic [SYNC_STAGES:0]    fill_q;
  logic [1:0]              s;
  logic [1:0]              prev_state;
  logic                    primed;
  logic [POS_WIDTH-1:0]    pos_q;
  logic                    dir_q;
  logic                    step_q;
  logic                    err_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] count_q;
  logic                    step_fwd;
  logic                    step_rev;
  logic                    illegal;
  logic                    step_accept;
  logic                    index_rise;

  assign s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  // Priming waits until the synchronizer holds real samples, so an encoder
  // resting at a non-00 state is not mistaken for a transition out of 00.
  assign primed = fill_q[SYNC_STAGES];

  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    illegal  = 1'b0;
    case ({prev_state, s})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_rev = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal  = 1'b1;
      default: ;
    endcase
  end

  assign step_accept = primed & bus.enable & (step_fwd | step_rev);

`ifdef INDEX_RESYNC_EN
  logic [SYNC_STAGES-1:0] idx_sync_q;
  logic                   idx_prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_sync_q <= '0;
      idx_prev_q <= 1'b0;
    end else begin
      idx_sync_q <= {idx_sync_q[SYNC_STAGES-2:0], bus.enc_index};
      idx_prev_q <= idx_sync_q[SYNC_STAGES-1];
    end
  end

  assign index_rise = primed & bus.enable & idx_sync_q[SYNC_STAGES-1] & ~idx_prev_q;
`else
  logic unused_index;
  assign unused_index = bus.enc_index;
  assign index_rise   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_sync_q   <= '0;
      b_sync_q   <= '0;
      fill_q     <= '0;
      prev_state <= 2'b00;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      period_q   <= PERIOD_MAX;
      count_q    <= '0;
    end else begin
      a_sync_q   <= {a_sync_q[SYNC_STAGES-2:0], bus.enc_a};
      b_sync_q   <= {b_sync_q[SYNC_STAGES-2:0], bus.enc_b};
      fill_q     <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      prev_state <= s;
      step_q     <= 1'b0;
      count_q    <= (count_q == PERIOD_MAX) ? count_q : count_q + 1'b1;

      // A new illegal transition outranks a coincident clear request.
      if (primed && illegal) begin
        err_q <= 1'b1;
      end else if (bus.clear_error) begin
        err_q <= 1'b0;
      end

      if (step_accept) begin
        if (step_fwd) begin
          pos_q <= (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
        end else begin
          pos_q <= (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
        end
        dir_q    <= step_fwd;
        step_q   <= 1'b1;
        period_q <= (count_q == PERIOD_MAX) ? PERIOD_MAX : count_q + 1'b1;
        count_q  <= '0;
      end

      if (index_rise) begin
        pos_q <= '0;
      end
    end
  end

  assign bus.cycle_position = pos_q;
  assign bus.direction      = dir_q;
  assign bus.step_valid     = step_q;
  assign bus.step_period    = period_q;
  assign bus.quad_error     = err_q;
endmodule

// File: tb/tb_quadrature_position_tracker.sv
// tb/tb_quadrature_position_tracker.sv - self-checking bench for quadrature_position_tracker
module tb_quadrature_position_tracker;
  localparam int CPC  = 1170;
  localparam int PMAX = 65535;

  logic clk;
  logic reset;
  int   cyc;
  int   sv_count;
  int   checks;
  int   failures;

  // reference model: position as plain modular arithmetic over the gray cycle
  int   m_pos;
  int   m_dir;
  int   m_err;
  int   m_steps;
  int   m_period;
  int   m_last;
  logic [1:0] m_cur;

  quadrature_position_tracker_if #(.POS_WIDTH(13), .PERIOD_WIDTH(16)) bus ();

  quadrature_position_tracker #(
    .COUNTS_PER_CYCLE(CPC),
    .POS_WIDTH(13),
    .SYNC_STAGES(2),
    .PERIOD_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial sv_count = 0;
  always @(negedge clk) if (bus.step_valid === 1'b1) sv_count++;

  function automatic int ord(input logic [1:0] x);
    case (x)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray_at(input int k);
    logic [1:0] tbl [4];
    tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
    return tbl[k % 4];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] st);
    int e;
    if (st != m_cur) begin
      if ((st ^ m_cur) == 2'b11) begin
        m_err = 1;
      end else if (bus.enable) begin
        if (ord(st) == (ord(m_cur) + 1) % 4) begin
          m_pos = (m_pos + 1) % CPC;
          m_dir = 1;
        end else begin
          m_pos = (m_pos + CPC - 1) % CPC;
          m_dir = 0;
        end
        m_steps++;
        e        = cyc + 3;
        m_period = (e - m_last > PMAX) ? PMAX : e - m_last;
        m_last   = e;
      end
    end
    m_cur     = st;
    bus.enc_a = st[1];
    bus.enc_b = st[0];
  endtask

  task automatic step_fwd();
    drive(gray_at(ord(m_cur) + 1));
  endtask

  task automatic step_rev();
    drive(gray_at(ord(m_cur) + 3));
  endtask

  task automatic do_reset(input logic [1:0] st);
    reset           = 1'b0;
    bus.enable      = 1'b1;
    bus.clear_error = 1'b0;
    bus.enc_index   = 1'b0;
    bus.enc_a       = st[1];
    bus.enc_b       = st[0];
    tick(3);
    m_last   = cyc;
    reset    = 1'b1;
    m_pos    = 0;
    m_dir    = 0;
    m_err    = 0;
    m_period = PMAX;
    m_cur    = st;
    tick(8);
  endtask

  task automatic test_reset();
    int base;
    base = sv_count;
    do_reset(2'b11);
    tick(10);
    checks += 5;
    if (bus.cycle_position !== 13'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", bus.cycle_position); end
    if (sv_count !== base) begin failures++; $display("FAIL reset_no_step got=%0d exp=%0d", sv_count, base); end
    if (bus.quad_error !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.quad_error); end
    if (bus.direction !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", bus.direction); end
    if (bus.step_period !== 16'hFFFF) begin failures++; $display("FAIL reset_period got=%0d exp=65535", bus.step_period); end
  endtask

  task automatic test_forward_sequence();
    do_reset(2'b00);
    for (int i = 1; i <= 4; i++) begin
      step_fwd();
      tick(2);
      checks += 2;
      if (bus.cycle_position !== 13'(i - 1)) begin failures++; $display("FAIL fwd_early_pos step=%0d got=%0d exp=%0d", i, bus.cycle_position, i - 1); end
      if (bus.step_valid !== 1'b0) begin failures++; $display("FAIL fwd_early_sv step=%0d got=%0b exp=0", i, bus.step_valid); end
      tick(1);
      checks += 3;
      if (bus.cycle_position !== 13'(i)) begin failures++; $display("FAIL fwd_pos step=%0d got=%0d exp=%0d", i, bus.cycle_position, i); end
      if (bus.step_valid !== 1'b1) begin failures++; $display("FAIL fwd_sv step=%0d got=%0b exp=1", i, bus.step_valid); end
      if (bus.direction !== 1'b1) begin failures++; $display("FAIL fwd_dir step=%0d got=%0b exp=1", i, bus.direction); end
      tick(1);
      checks += 1;
      if (bus.step_valid !== 1'b0) begin failures++; $display("FAIL fwd_sv_pulse step=%0d got=%0b exp=0", i, bus.step_valid); end
      if (i == 2) begin
        checks += 1;
        if (bus.step_period !== 16'd20) begin failures++; $display("FAIL fwd_period got=%0d exp=20", bus.step_period); end
      end
      tick(16);
    end
  endtask

  task automatic test_wrap();
    while (m_pos != CPC - 1) begin
      step_fwd();
      tick(4);
    end
    checks += 1;
    if (bus.cycle_position !== 13'(CPC - 1)) begin failures++; $display("FAIL wrap_preload got=%0d exp=%0d", bus.cycle_position, CPC - 1); end
    step_fwd();
    tick(5);
    checks += 1;
    if (bus.cycle_position !== 13'd0) begin failures++; $display("FAIL wrap_up got=%0d exp=0", bus.cycle_position); end
    step_rev();
    tick(5);
    checks += 2;
    if (bus.cycle_position !== 13'(CPC - 1)) begin failures++; $display("FAIL wrap_down got=%0d exp=%0d", bus.cycle_position, CPC - 1); end
    if (bus.direction !== 1'b0) begin failures++; $display("FAIL wrap_dir got=%0b exp=0", bus.direction); end
  endtask

  task automatic test_error();
    int p;
    do_reset(2'b00);
    p = m_pos;
    drive(2'b11);
    tick(5);
    checks += 2;
    if (bus.quad_error !== 1'b1) begin failures++; $display("FAIL err_set got=%0b exp=1", bus.quad_error); end
    if (bus.cycle_position !== 13'(p)) begin failures++; $display("FAIL err_pos got=%0d exp=%0d", bus.cycle_position, p); end
    drive(2'b01);
    tick(5);
    drive(2'b10);
    tick(2);
    bus.clear_error = 1'b1;
    tick(1);
    bus.clear_error = 1'b0;
    tick(3);
    checks += 2;
    if (bus.quad_error !== 1'b1) begin failures++; $display("FAIL err_set_wins got=%0b exp=1", bus.quad_error); end
    if (bus.cycle_position !== 13'(m_pos)) begin failures++; $display("FAIL err_pos2 got=%0d exp=%0d", bus.cycle_position, m_pos); end
    bus.clear_error = 1'b1;
    tick(1);
    bus.clear_error = 1'b0;
    m_err = 0;
    tick(2);
    checks += 1;
    if (bus.quad_error !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b exp=0", bus.quad_error); end
  endtask

  task automatic test_enable_and_saturation();
    int p;
    int base;
    p    = m_pos;
    base = sv_count;
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_fwd();
      tick(5);
    end
    checks += 2;
    if (bus.cycle_position !== 13'(p)) begin failures++; $display("FAIL en_hold_pos got=%0d exp=%0d", bus.cycle_position, p); end
    if (sv_count !== base) begin failures++; $display("FAIL en_hold_sv got=%0d exp=%0d", sv_count, base); end
    bus.enable = 1'b1;
    tick(6);
    checks += 1;
    if (sv_count !== base) begin failures++; $display("FAIL en_glitch got=%0d exp=%0d", sv_count, base); end
    step_fwd();
    tick(5);
    checks += 2;
    if (bus.cycle_position !== 13'((p + 1) % CPC)) begin failures++; $display("FAIL en_step got=%0d exp=%0d", bus.cycle_position, (p + 1) % CPC); end
    if (sv_count !== base + 1) begin failures++; $display("FAIL en_step_sv got=%0d exp=%0d", sv_count, base + 1); end
    tick(70000);
    step_fwd();
    tick(5);
    checks += 1;
    if (bus.step_period !== 16'hFFFF) begin failures++; $display("FAIL period_sat got=%0d exp=65535", bus.step_period); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) bus.enable = ~bus.enable;
      r = $urandom_range(0, 99);
      if (r < 45)      step_fwd();
      else if (r < 90) step_rev();
      else if (r < 95) drive(m_cur);
      else             drive(m_cur ^ 2'b11);
      tick($urandom_range(4, 8));
      if (m_err == 1 && $urandom_range(0, 3) == 0) begin
        bus.clear_error = 1'b1;
        tick(1);
        bus.clear_error = 1'b0;
        m_err = 0;
        tick(1);
      end
      checks += 5;
      if (bus.cycle_position !== 13'(m_pos)) begin failures++; $display("FAIL rnd_pos it=%0d got=%0d exp=%0d", i, bus.cycle_position, m_pos); end
      if (bus.direction !== m_dir[0]) begin failures++; $display("FAIL rnd_dir it=%0d got=%0b exp=%0d", i, bus.direction, m_dir); end
      if (bus.quad_error !== m_err[0]) begin failures++; $display("FAIL rnd_err it=%0d got=%0b exp=%0d", i, bus.quad_error, m_err); end
      if (bus.step_period !== 16'(m_period)) begin failures++; $display("FAIL rnd_period it=%0d got=%0d exp=%0d", i, bus.step_period, m_period); end
      if (sv_count !== m_steps) begin failures++; $display("FAIL rnd_steps it=%0d got=%0d exp=%0d", i, sv_count, m_steps); end
    end
    bus.enable = 1'b1;
  endtask

`ifdef INDEX_RESYNC_EN
  task automatic test_index();
    do_reset(2'b00);
    while (m_pos != 500) begin
      step_fwd();
      tick(4);
    end
    bus.enc_index = 1'b1;
    step_fwd();
    m_pos = 0;
    tick(3);
    checks += 3;
    if (bus.cycle_position !== 13'd0) begin failures++; $display("FAIL idx_pos got=%0d exp=0", bus.cycle_position); end
    if (bus.direction !== 1'b1) begin failures++; $display("FAIL idx_dir got=%0b exp=1", bus.direction); end
    if (bus.step_valid !== 1'b1) begin failures++; $display("FAIL idx_sv got=%0b exp=1", bus.step_valid); end
    tick(5);
    bus.enc_index = 1'b0;
    tick(5);
    checks += 1;
    if (bus.cycle_position !== 13'd0) begin failures++; $display("FAIL idx_hold got=%0d exp=0", bus.cycle_position); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    m_steps  = 0;
    reset    = 1'b0;
    test_reset();
    test_forward_sequence();
    test_wrap();
    test_error();
    test_enable_and_saturation();
    test_random();
`ifdef INDEX_RESYNC_EN
    test_index();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
